// File: rtl/integration_sysid_checker.sv
// Avalon-MM read master that reads the sysid ID and timestamp words and checks them
// against expected values. The pass/fail/timeout status is held on registered outputs.
module integration_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd1395937365,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1542221001,
  parameter bit          CHECK_TIMESTAMP    = 1'b1,
  parameter bit          AUTO_START         = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES     = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic        avm_readdatavalid,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ID   = 3'd1,
    S_WAIT_ID = 3'd2,
    S_RD_TS   = 3'd3,
    S_WAIT_TS = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  logic        auto_done_q, auto_done_d;
  logic [7:0]  tcnt_q, tcnt_d;
  logic        avm_read_q, avm_read_d;
  logic        avm_address_q, avm_address_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        id_mismatch_q, id_mismatch_d;
  logic        ts_mismatch_q, ts_mismatch_d;
  logic        timeout_q, timeout_d;
  logic [31:0] captured_id_q, captured_id_d;
  logic [31:0] captured_ts_q, captured_ts_d;

  logic        go_s, rd_state_s, accept_s, word_valid_s, to_hit_s, enter_done_s;
  logic [7:0]  tcnt_inc_s;

  // Next-state and registered-output computation
  always_comb begin
    state_d       = state_q;
    auto_done_d   = 1'b1;
    tcnt_d        = tcnt_q;
    avm_read_d    = avm_read_q;
    avm_address_d = avm_address_q;
    busy_d        = busy_q;
    done_d        = done_q;
    pass_d        = pass_q;
    id_mismatch_d = id_mismatch_q;
    ts_mismatch_d = ts_mismatch_q;
    timeout_d     = timeout_q;
    captured_id_d = captured_id_q;
    captured_ts_d = captured_ts_q;
    enter_done_s  = 1'b0;

    go_s         = start | (AUTO_START & ~auto_done_q);
    rd_state_s   = (state_q == S_RD_ID) || (state_q == S_RD_TS);
    accept_s     = rd_state_s & ~avm_waitrequest;
    word_valid_s = avm_readdatavalid &
                   (accept_s | (state_q == S_WAIT_ID) | (state_q == S_WAIT_TS));
    tcnt_inc_s   = tcnt_q + 8'd1;
    to_hit_s     = (tcnt_inc_s == TO_LIMIT);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (go_s) begin
          state_d       = S_RD_ID;
          tcnt_d        = 8'd0;
          avm_read_d    = 1'b1;
          avm_address_d = 1'b0;
          busy_d        = 1'b1;
          done_d        = 1'b0;
          pass_d        = 1'b0;
          id_mismatch_d = 1'b0;
          ts_mismatch_d = 1'b0;
          timeout_d     = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      S_RD_ID, S_WAIT_ID, S_RD_TS, S_WAIT_TS: begin
        // Data arriving on the limit edge wins over the timeout
        if (word_valid_s) begin
          if ((state_q == S_RD_ID) || (state_q == S_WAIT_ID)) begin
            captured_id_d = avm_readdata;
            id_mismatch_d = (avm_readdata != EXPECTED_ID);
            state_d       = S_RD_TS;
            tcnt_d        = 8'd0;
            avm_read_d    = 1'b1;
            avm_address_d = 1'b1;
          end else begin
            captured_ts_d = avm_readdata;
            ts_mismatch_d = (avm_readdata != EXPECTED_TIMESTAMP);
            state_d       = S_DONE;
            avm_read_d    = 1'b0;
            enter_done_s  = 1'b1;
          end
        end else if (to_hit_s) begin
          tcnt_d       = tcnt_inc_s;
          timeout_d    = 1'b1;
          avm_read_d   = 1'b0;
          state_d      = S_DONE;
          enter_done_s = 1'b1;
        end else begin
          tcnt_d = tcnt_inc_s;
          if (accept_s) begin
            avm_read_d = 1'b0;
            state_d    = (state_q == S_RD_ID) ? S_WAIT_ID : S_WAIT_TS;
          end else begin
            state_d = state_q;
          end
        end
      end
      default: begin
        state_d    = S_IDLE;
        avm_read_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase

    if (enter_done_s) begin
      busy_d = 1'b0;
      done_d = 1'b1;
      pass_d = ~timeout_d & ~id_mismatch_d & (~ts_mismatch_d | ~CHECK_TIMESTAMP);
    end else begin
      pass_d = pass_d;
    end
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      auto_done_q   <= 1'b0;
      tcnt_q        <= 8'd0;
      avm_read_q    <= 1'b0;
      avm_address_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      id_mismatch_q <= 1'b0;
      ts_mismatch_q <= 1'b0;
      timeout_q     <= 1'b0;
      captured_id_q <= 32'd0;
      captured_ts_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      auto_done_q   <= auto_done_d;
      tcnt_q        <= tcnt_d;
      avm_read_q    <= avm_read_d;
      avm_address_q <= avm_address_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      id_mismatch_q <= id_mismatch_d;
      ts_mismatch_q <= ts_mismatch_d;
      timeout_q     <= timeout_d;
      captured_id_q <= captured_id_d;
      captured_ts_q <= captured_ts_d;
    end
  end

  assign avm_read    = avm_read_q;
  assign avm_address = avm_address_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign id_mismatch = id_mismatch_q;
  assign ts_mismatch = ts_mismatch_q;
  assign timeout     = timeout_q;
  assign captured_id = captured_id_q;
  assign captured_ts = captured_ts_q;

endmodule

// File: tb/tb_integration_sysid_checker.sv
// Bench for integration_sysid_checker: a configurable sysid slave answers DUT a; DUT b
// (timestamp mismatches not enforced) shadows it. Results come from a per-word cost model.
module tb_integration_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'd1395937365;
  localparam logic [31:0] EXP_TS = 32'd1542221001;
  localparam int          TO     = 16;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        wr = 1'b0;
  logic        rdv = 1'b0;
  logic [31:0] rdata = 32'd0;

  logic        a_addr, a_read, a_busy, a_done, a_pass, a_idm, a_tsm, a_to;
  logic [31:0] a_cid, a_cts;
  logic        b_addr, b_read, b_busy, b_done, b_pass, b_idm, b_tsm, b_to;
  logic [31:0] b_cid, b_cts;

  integration_sysid_checker #(.EXPECTED_ID(EXP_ID), .EXPECTED_TIMESTAMP(EXP_TS),
    .CHECK_TIMESTAMP(1'b1), .AUTO_START(1'b1), .TIMEOUT_CYCLES(TO)) dut_a (
    .clock(clock), .reset_n(reset_n), .start(start),
    .avm_address(a_addr), .avm_read(a_read), .avm_waitrequest(wr),
    .avm_readdatavalid(rdv), .avm_readdata(rdata),
    .busy(a_busy), .done(a_done), .pass(a_pass), .id_mismatch(a_idm),
    .ts_mismatch(a_tsm), .timeout(a_to), .captured_id(a_cid), .captured_ts(a_cts));

  integration_sysid_checker #(.EXPECTED_ID(EXP_ID), .EXPECTED_TIMESTAMP(EXP_TS),
    .CHECK_TIMESTAMP(1'b0), .AUTO_START(1'b1), .TIMEOUT_CYCLES(TO)) dut_b (
    .clock(clock), .reset_n(reset_n), .start(start),
    .avm_address(b_addr), .avm_read(b_read), .avm_waitrequest(wr),
    .avm_readdatavalid(rdv), .avm_readdata(rdata),
    .busy(b_busy), .done(b_done), .pass(b_pass), .id_mismatch(b_idm),
    .ts_mismatch(b_tsm), .timeout(b_to), .captured_id(b_cid), .captured_ts(b_cts));

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // slave configuration and state
  int          cfg_ws, cfg_lat;
  bit          cfg_stuck;
  logic [31:0] mem0, mem1;
  int          ws_left, pend_left;
  bit          pend, req_active;
  logic        pend_addr, req_addr;

  // model of last captured words
  logic [31:0] m_cid = 32'd0;
  logic [31:0] m_cts = 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_flags"}, 32'({a_read, a_addr, a_busy, a_done, a_pass, a_idm, a_tsm, a_to}), 32'd0);
    chk({tag, "_cid"}, a_cid, 32'd0);
    chk({tag, "_cts"}, a_cts, 32'd0);
    chk({tag, "_b_flags"}, 32'({b_read, b_busy, b_done, b_pass}), 32'd0);
  endtask

  task automatic slave_reset();
    wr = 1'b0; rdv = 1'b0; rdata = 32'd0;
    pend = 1'b0; req_active = 1'b0; ws_left = 0; pend_left = 0;
  endtask

  // one slave cycle, called at a falling edge to set inputs for the next rising edge
  task automatic slave_cycle();
    wr = 1'b0; rdv = 1'b0;
    if (pend) begin
      if (pend_left == 0) begin
        rdv = 1'b1; rdata = pend_addr ? mem1 : mem0; pend = 1'b0;
      end else begin
        pend_left--;
      end
    end
    if (a_read) begin
      if (req_active) chk("addr_stable", 32'(a_addr), 32'(req_addr));
      else begin
        req_active = 1'b1; req_addr = a_addr; ws_left = cfg_ws;
      end
      if (cfg_stuck || ws_left > 0) begin
        wr = 1'b1;
        if (ws_left > 0) ws_left--;
      end else begin
        req_active = 1'b0;
        if (cfg_lat == 0) begin
          rdv = 1'b1; rdata = a_addr ? mem1 : mem0;
        end else begin
          pend = 1'b1; pend_left = cfg_lat - 1; pend_addr = a_addr;
        end
      end
    end
  endtask

  // runs one check from a falling edge; returns early (aborted=1) once in the timestamp wait
  task automatic run_check(input string tag, input bit use_start, input bit poke_busy,
                           input bit abort_wts, output bit aborted);
    int  n, cost, exp_cycles;
    bit  fin, e_to, e_idm, e_tsm;
    aborted = 1'b0;
    slave_reset();
    if (use_start) start = 1'b1;
    n = 0; fin = 1'b0;
    while (!fin && n < 100) begin
      @(posedge clock);
      n++;
      @(negedge clock);
      start = 1'b0;
      if (poke_busy && n == 2) start = 1'b1;
      if (n == 1) chk({tag, "_busy1"}, 32'(a_busy), 32'd1);
      if (a_done) fin = 1'b1;
      else if (abort_wts && a_busy && a_addr && !a_read) begin
        aborted = 1'b1;
        return;
      end else slave_cycle();
    end
    cost = cfg_ws + cfg_lat + 1;
    e_to = cfg_stuck;
    if (e_to) begin
      exp_cycles = 1 + TO;
      e_idm = 1'b0; e_tsm = 1'b0;
    end else begin
      exp_cycles = 1 + 2 * cost;
      e_idm = (mem0 != EXP_ID); e_tsm = (mem1 != EXP_TS);
      m_cid = mem0; m_cts = mem1;
    end
    chk({tag, "_cycles"}, 32'(n), 32'(exp_cycles));
    chk({tag, "_busy"}, 32'(a_busy), 32'd0);
    chk({tag, "_read"}, 32'(a_read), 32'd0);
    chk({tag, "_timeout"}, 32'(a_to), 32'(e_to));
    chk({tag, "_idm"}, 32'(a_idm), 32'(e_idm));
    chk({tag, "_tsm"}, 32'(a_tsm), 32'(e_tsm));
    chk({tag, "_pass"}, 32'(a_pass), 32'(!e_to && !e_idm && !e_tsm));
    chk({tag, "_b_pass"}, 32'(b_pass), 32'(!e_to && !e_idm));
    chk({tag, "_b_done"}, 32'(b_done), 32'd1);
    chk({tag, "_cid"}, a_cid, m_cid);
    chk({tag, "_cts"}, a_cts, m_cts);
  endtask

  initial begin
    bit ab;
    cfg_ws = 0; cfg_lat = 0; cfg_stuck = 1'b0;
    mem0 = EXP_ID; mem1 = EXP_TS;
    slave_reset();
    repeat (3) @(negedge clock);
    chk_all_zero("reset");

    reset_n = 1'b1;
    run_check("auto_zero_wait", 1'b0, 1'b0, 1'b0, ab);

    mem0 = 32'hDEADBEEF;
    run_check("bad_id", 1'b1, 1'b0, 1'b0, ab);

    mem0 = EXP_ID; mem1 = EXP_TS + 32'd1;
    run_check("bad_ts", 1'b1, 1'b0, 1'b0, ab);

    mem1 = EXP_TS; cfg_ws = 3; cfg_lat = 2;
    run_check("stall", 1'b1, 1'b1, 1'b0, ab);

    cfg_stuck = 1'b1;
    run_check("stuck", 1'b1, 1'b0, 1'b0, ab);

    cfg_stuck = 1'b0; cfg_ws = 0; cfg_lat = 0;
    run_check("recover", 1'b1, 1'b0, 1'b0, ab);

    cfg_ws = 1; cfg_lat = 4;
    run_check("abort", 1'b1, 1'b0, 1'b1, ab);
    chk("abort_reached_wait_ts", 32'(ab), 32'd1);
    reset_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    m_cid = 32'd0; m_cts = 32'd0;
    @(negedge clock);
    reset_n = 1'b1;
    cfg_ws = 0; cfg_lat = 0;
    run_check("rerun", 1'b0, 1'b1, 1'b0, ab);

    for (int i = 0; i < 20; i++) begin
      cfg_ws    = int'($urandom_range(0, 5));
      cfg_lat   = int'($urandom_range(0, 5));
      cfg_stuck = ($urandom_range(0, 7) == 0);
      mem0 = ($urandom_range(0, 2) == 0) ? $urandom : EXP_ID;
      mem1 = ($urandom_range(0, 2) == 0) ? $urandom : EXP_TS;
      run_check("random", 1'b1, 1'($urandom_range(0, 1)), 1'b0, ab);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
